// File: rtl/pdh_dac_pkg.sv
// rtl/pdh_dac_pkg.sv - shared types and constants for the DAC write path
//
// Purpose: write-sequencer state encoding, the midscale (~0 V) code and the
// channel-select encoding used by dac_write_arbiter and its readback logic.
package pdh_dac_pkg;

  // Write sequencer states. 2-bit encoding keeps the state register minimal.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } dac_wr_state_t;

  // Reset and shadow code for a 14-bit offset-binary DAC (~0 V output).
  localparam logic [13:0] DAC_MIDSCALE = 14'h2000;

  // Channel select encoding on the interleaved write port.
  localparam logic DAC_CH_A = 1'b0;
  localparam logic DAC_CH_B = 1'b1;

endpackage

// File: rtl/dac_write_arbiter_rr_arbiter.sv
// rtl/dac_write_arbiter_rr_arbiter.sv - round-robin requester selection
//
// Purpose: picks the first valid requester starting at the rotating pointer
// and advances the pointer past the winner when the caller commits a grant.
//
// Ports:
//   clk       in   system clock
//   rst_ni    in   asynchronous active-low reset (pointer returns to 0)
//   req_i     in   N   request vector
//   en_i      in   1   grant enable; grant_o is forced to zero when low
//   update_i  in   1   commit strobe; pointer <= (idx_o + 1) mod N
//   grant_o   out  N   one-hot grant (or zero)
//   idx_o     out  IW  index of the selected requester
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  input  logic          update_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  // Scan p, p+1, ... wrapping at N; the first hit wins. The wrap is done
  // explicitly so non-power-of-two N never selects a non-existent requester.
  always_comb begin
    int   cand;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand[IW-1:0];
      end
    end
    if (!en_i) begin
      grant_o = '0;
    end
  end

  always_comb begin
    if (idx_o == IW'(N - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (update_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dac_write_arbiter.sv
// rtl/dac_write_arbiter.sv - round-robin arbiter and write sequencer for the dual-channel DAC port
//
// Purpose: shares one interleaved dual-channel DAC write port between
// NUM_REQ requesters. Each accepted write is sequenced SETUP -> STROBE ->
// HOLD; the code committed to each channel is mirrored in a shadow register.
//
// Ports:
//   clk          in   system clock
//   rst_ni       in   asynchronous active-low reset
//   req_valid_i  in   NUM_REQ        per-requester write request
//   req_ready_o  out  NUM_REQ        per-requester accept (one-hot or zero)
//   req_data_i   in   NUM_REQ*W      packed codes, requester i at [i*W +: W]
//   req_sel_i    in   NUM_REQ        channel select per requester (0 = A, 1 = B)
//   dac_dat_o    out  W              DAC data bus
//   dac_sel_o    out  1              DAC channel select
//   dac_wrt_o    out  1              DAC write strobe
//   dac_a_o      out  W              shadow of last code committed to channel A
//   dac_b_o      out  W              shadow of last code committed to channel B
//   busy_o       out  1              high whenever a write is in progress
//   grant_idx_o  out  clog2(NUM_REQ) index of the last granted requester
module dac_write_arbiter #(
  parameter  int                        NUM_REQ        = 2,
  parameter  int                        DAC_DATA_WIDTH = 14,
  parameter  logic [DAC_DATA_WIDTH-1:0] DAC_MIDSCALE   = pdh_dac_pkg::DAC_MIDSCALE,
  parameter  int                        HOLD_CYCLES    = 1,
  localparam int                        IW             = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst_ni,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ*DAC_DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]                req_sel_i,
  output logic [DAC_DATA_WIDTH-1:0]         dac_dat_o,
  output logic                              dac_sel_o,
  output logic                              dac_wrt_o,
  output logic [DAC_DATA_WIDTH-1:0]         dac_a_o,
  output logic [DAC_DATA_WIDTH-1:0]         dac_b_o,
  output logic                              busy_o,
  output logic [IW-1:0]                     grant_idx_o
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  pdh_dac_pkg::dac_wr_state_t state_q;

  logic [3:0]                hold_cnt_q;
  logic [DAC_DATA_WIDTH-1:0] dat_q;
  logic                      sel_q;
  logic                      wrt_q;
  logic [DAC_DATA_WIDTH-1:0] shadow_a_q;
  logic [DAC_DATA_WIDTH-1:0] shadow_b_q;
  logic                      busy_q;
  logic [IW-1:0]             grant_idx_q;

  logic                      arb_en;
  logic [NUM_REQ-1:0]        arb_grant;
  logic [IW-1:0]             arb_idx;
  logic                      accept;
  logic [DAC_DATA_WIDTH-1:0] win_data;
  logic                      win_sel;

  // Ready is only offered while idle. It is also masked by rst_ni so a
  // requester cannot see ready while the block is held in reset.
  assign arb_en = (state_q == pdh_dac_pkg::IDLE) && rst_ni;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .clk      (clk),
    .rst_ni   (rst_ni),
    .req_i    (req_valid_i),
    .en_i     (arb_en),
    .update_i (accept),
    .grant_o  (arb_grant),
    .idx_o    (arb_idx)
  );

  assign req_ready_o = arb_grant;
  assign accept      = |(arb_grant & req_valid_i);
  assign win_data    = req_data_i[int'(arb_idx)*DAC_DATA_WIDTH +: DAC_DATA_WIDTH];
  assign win_sel     = req_sel_i[arb_idx];

  // Write sequencer. All DAC-facing outputs are registered here so the bus
  // never glitches; wrt_q is set on entry to STROBE and cleared on exit.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= pdh_dac_pkg::IDLE;
      hold_cnt_q  <= '0;
      dat_q       <= DAC_MIDSCALE;
      sel_q       <= pdh_dac_pkg::DAC_CH_A;
      wrt_q       <= 1'b0;
      shadow_a_q  <= DAC_MIDSCALE;
      shadow_b_q  <= DAC_MIDSCALE;
      busy_q      <= 1'b0;
      grant_idx_q <= '0;
    end else begin
      case (state_q)
        pdh_dac_pkg::IDLE: begin
          if (accept) begin
            dat_q       <= win_data;
            sel_q       <= win_sel;
            grant_idx_q <= arb_idx;
            busy_q      <= 1'b1;
            state_q     <= pdh_dac_pkg::SETUP;
          end
        end
        pdh_dac_pkg::SETUP: begin
          wrt_q   <= 1'b1;
          state_q <= pdh_dac_pkg::STROBE;
        end
        pdh_dac_pkg::STROBE: begin
          // The strobe cycle completes the DAC write, so the shadow of the
          // addressed channel commits on this edge.
          wrt_q      <= 1'b0;
          hold_cnt_q <= HOLD_LOAD;
          if (sel_q == pdh_dac_pkg::DAC_CH_A) begin
            shadow_a_q <= dat_q;
          end else begin
            shadow_b_q <= dat_q;
          end
          state_q <= pdh_dac_pkg::HOLD;
        end
        pdh_dac_pkg::HOLD: begin
          if (hold_cnt_q == 4'd0) begin
            busy_q  <= 1'b0;
            state_q <= pdh_dac_pkg::IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q - 4'd1;
          end
        end
        default: begin
          wrt_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= pdh_dac_pkg::IDLE;
        end
      endcase
    end
  end

  assign dac_dat_o   = dat_q;
  assign dac_sel_o   = sel_q;
  assign dac_wrt_o   = wrt_q;
  assign dac_a_o     = shadow_a_q;
  assign dac_b_o     = shadow_b_q;
  assign busy_o      = busy_q;
  assign grant_idx_o = grant_idx_q;

endmodule

// File: tb/tb_dac_write_arbiter.sv
// tb/tb_dac_write_arbiter.sv - self-checking bench for dac_write_arbiter
module tb_dac_write_arbiter;

  localparam logic [13:0] MID = 14'h2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  valid;
  logic [27:0] data;
  logic [1:0]  sel;
  logic [1:0]  ready;
  logic [13:0] dat, a, b;
  logic        dsel, wrt, busy, gidx;

  logic [1:0]  v4;
  logic [27:0] d4;
  logic [1:0]  s4;
  logic [1:0]  ready4;
  logic [13:0] dat4, a4, b4;
  logic        dsel4, wrt4, busy4, gidx4;

  dac_write_arbiter #(.NUM_REQ(2), .DAC_DATA_WIDTH(14), .DAC_MIDSCALE(14'h2000), .HOLD_CYCLES(1)) dut (
    .clk(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_ready_o(ready), .req_data_i(data),
    .req_sel_i(sel), .dac_dat_o(dat), .dac_sel_o(dsel), .dac_wrt_o(wrt), .dac_a_o(a),
    .dac_b_o(b), .busy_o(busy), .grant_idx_o(gidx));

  dac_write_arbiter #(.NUM_REQ(2), .DAC_DATA_WIDTH(14), .DAC_MIDSCALE(14'h2000), .HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst_ni(rst_n), .req_valid_i(v4), .req_ready_o(ready4), .req_data_i(d4),
    .req_sel_i(s4), .dac_dat_o(dat4), .dac_sel_o(dsel4), .dac_wrt_o(wrt4), .dac_a_o(a4),
    .dac_b_o(b4), .busy_o(busy4), .grant_idx_o(gidx4));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: transaction-level timing for HOLD_CYCLES = 1.
  int          cyc, free_cyc, acc_cyc, strobe_cyc, upd_cyc, ptr, win;
  logic [13:0] m_dat, m_a, m_b, upd_dat;
  logic        m_sel, upd_sel;
  int          m_gidx;
  int          pulses[$];
  int          gseq[$];
  int          grants[$];

  task automatic model_reset();
    m_dat = MID; m_sel = 1'b0; m_a = MID; m_b = MID;
    free_cyc = 0; acc_cyc = -100; strobe_cyc = -100; upd_cyc = -100;
    ptr = 0; m_gidx = 0; win = -1;
  endtask

  task automatic clear_logs();
    pulses.delete(); gseq.delete(); grants.delete();
  endtask

  task automatic chk_phase(input string tag);
    logic [31:0] er;
    @(negedge clk);
    if (cyc == upd_cyc) begin
      if (upd_sel) m_b = upd_dat;
      else         m_a = upd_dat;
    end
    win = -1;
    if (cyc >= free_cyc) begin
      for (int k = 0; k < 2; k++) begin
        int i;
        i = (ptr + k) % 2;
        if (win < 0 && valid[i]) win = i;
      end
    end
    er = (win < 0) ? 32'd0 : (32'd1 << win);
    chk({tag, ".ready"}, 32'(ready), er);
    chk({tag, ".wrt"},   32'(wrt),   32'(cyc == strobe_cyc));
    chk({tag, ".dat"},   32'(dat),   32'(m_dat));
    chk({tag, ".sel"},   32'(dsel),  32'(m_sel));
    chk({tag, ".a"},     32'(a),     32'(m_a));
    chk({tag, ".b"},     32'(b),     32'(m_b));
    chk({tag, ".busy"},  32'(busy),  32'(cyc > acc_cyc && cyc < free_cyc));
    chk({tag, ".gidx"},  32'(gidx),  32'(m_gidx));
    if (wrt === 1'b1) pulses.push_back(cyc);
    if (cyc == acc_cyc + 1) gseq.push_back(int'(gidx));
    if (win >= 0) begin
      acc_cyc    = cyc;
      m_dat      = data[win*14 +: 14];
      m_sel      = sel[win];
      strobe_cyc = cyc + 2;
      upd_cyc    = cyc + 3;
      upd_dat    = m_dat;
      upd_sel    = m_sel;
      free_cyc   = cyc + 4;
      ptr        = (win + 1) % 2;
      m_gidx     = win;
      grants.push_back(win);
    end
  endtask

  task automatic tick(input string tag);
    chk_phase(tag);
    @(posedge clk); cyc++; #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [13:0] d, input logic s);
    valid[i] = v; data[i*14 +: 14] = d; sel[i] = s;
  endtask

  task automatic new_item(input int i);
    logic [13:0] d;
    case ($urandom_range(0, 5))
      0:       d = 14'h0000;
      1:       d = 14'h3FFF;
      default: d = 14'($urandom);
    endcase
    set_req(i, 1'b1, d, 1'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = '0;
    model_reset();
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    #1 rst_n = 1'b1;
  endtask

  int          p4[$];
  logic [13:0] hd[0:39];
  logic        hs[0:39];
  logic        hit;

  initial begin
    rst_n = 1'b0; valid = '0; data = '0; sel = '0;
    v4 = '0; d4 = '0; s4 = '0; cyc = 0;
    model_reset();
    do_reset();

    // 1: idle after reset
    repeat (20) tick("t1");

    // 2: single write req0 -> channel B
    set_req(0, 1'b1, 14'h1ABC, 1'b1);
    for (int n = 0; n < 10; n++) begin
      tick("t2");
      if (win == 0) valid[0] = 1'b0;
    end
    chk("t2.b_final", 32'(b), 32'h1ABC);
    chk("t2.a_final", 32'(a), 32'(MID));

    // 3: contention from reset, req0 first
    do_reset(); clear_logs();
    set_req(0, 1'b1, 14'h0100, 1'b0);
    set_req(1, 1'b1, 14'h3F00, 1'b1);
    for (int n = 0; n < 14; n++) begin
      tick("t3");
      if (win >= 0) valid[win] = 1'b0;
    end
    chk("t3.npulse", 32'(pulses.size()), 32'd2);
    chk("t3.spacing", 32'((pulses.size() >= 2) ? pulses[1] - pulses[0] : -1), 32'd4);
    chk("t3.gfirst", 32'((gseq.size() >= 1) ? gseq[0] : -1), 32'd0);
    chk("t3.a", 32'(a), 32'h0100);
    chk("t3.b", 32'(b), 32'h3F00);

    // 4: fairness over 8 writes
    do_reset(); clear_logs();
    new_item(0); new_item(1);
    for (int n = 0; n < 60 && grants.size() < 8; n++) begin
      tick("t4");
      if (win >= 0) new_item(win);
    end
    valid = '0;
    repeat (6) tick("t4d");
    chk("t4.npulse", 32'(pulses.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t4.gseq%0d", k), 32'((gseq.size() > k) ? gseq[k] : -1), 32'(k % 2));
    end

    // 5: reset asserted during STROBE
    do_reset(); clear_logs();
    set_req(0, 1'b1, 14'h0555, 1'b0);
    hit = 1'b0;
    for (int n = 0; n < 10; n++) begin
      chk_phase("t5");
      if (cyc == strobe_cyc) begin hit = 1'b1; break; end
      @(posedge clk); cyc++; #1;
    end
    chk("t5.reached_strobe", 32'(hit), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5.wrt_async", 32'(wrt), 32'd0);
    chk("t5.ready_rst", 32'(ready), 32'd0);
    chk("t5.dat_rst", 32'(dat), 32'(MID));
    chk("t5.a_rst", 32'(a), 32'(MID));
    chk("t5.b_rst", 32'(b), 32'(MID));
    chk("t5.busy_rst", 32'(busy), 32'd0);
    model_reset(); clear_logs();
    @(posedge clk); cyc++;
    #1 rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick("t5r");
      if (win == 0) valid[0] = 1'b0;
    end
    chk("t5.npulse_after", 32'(pulses.size()), 32'd1);
    chk("t5.a_after", 32'(a), 32'h0555);

    // random: arbitrary request/withdraw traffic against the model
    do_reset(); clear_logs();
    for (int n = 0; n < 400; n++) begin
      tick("rnd");
      for (int i = 0; i < 2; i++) begin
        if (valid[i] && win == i) begin
          if ($urandom_range(0, 1) == 1) new_item(i);
          else valid[i] = 1'b0;
        end else if (valid[i]) begin
          if ($urandom_range(0, 7) == 0) valid[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          new_item(i);
        end
      end
    end
    valid = '0;
    repeat (8) tick("rndd");

    // 6: HOLD_CYCLES = 4, back-to-back writes from req1
    @(posedge clk); #1;
    v4 = 2'b10; d4[27:14] = 14'h2AAA; s4 = 2'b10;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      hd[c] = dat4; hs[c] = dsel4;
      if (wrt4 === 1'b1) p4.push_back(c);
    end
    v4 = '0;
    chk("t6.npulse", 32'(p4.size()), 32'd6);
    chk("t6.first", 32'((p4.size() > 0) ? p4[0] : -1), 32'd2);
    for (int k = 1; k < 6; k++) begin
      chk($sformatf("t6.spacing%0d", k), 32'((p4.size() > k) ? p4[k] - p4[k-1] : -1), 32'd7);
    end
    for (int k = 0; k < p4.size(); k++) begin
      for (int j = 1; j <= 4; j++) begin
        if (p4[k] + j < 40) begin
          chk($sformatf("t6.hold_dat%0d_%0d", k, j), 32'(hd[p4[k] + j]), 32'h2AAA);
          chk($sformatf("t6.hold_sel%0d_%0d", k, j), 32'(hs[p4[k] + j]), 32'd1);
        end
      end
    end
    chk("t6.b4", 32'(b4), 32'h2AAA);
    chk("t6.a4", 32'(a4), 32'(MID));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dac_write_arbiter.md
Name: dac_write_arbiter

Overview:
- Shares the single interleaved dual-channel DAC write port between NUM_REQ requesters, e.g. the PS command path and an on-fabric sweep or lock loop.
- Each requester presents a 14-bit code and a channel select over a valid/ready handshake.
- The block grants requesters round-robin and sequences each write as setup, write strobe, then hold.
- It keeps per-channel shadow registers of the last code written, for PS readback.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- DAC_DATA_WIDTH, 14, DAC code width.
- DAC_MIDSCALE, 14'h2000, reset and shadow code (~0 V).
- HOLD_CYCLES, 1, cycles data/sel stay stable after the strobe; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst_ni  in  1  reset; one clock; asynchronous assert, active-low.
- req_valid_i  in  NUM_REQ  per-requester write request.
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_data_i  in  NUM_REQ*DAC_DATA_WIDTH  packed codes; requester i occupies bits [i*W +: W].
- req_sel_i  in  NUM_REQ  channel select per requester; 0 = A, 1 = B.
- dac_dat_o  out  DAC_DATA_WIDTH  DAC data bus.
- dac_sel_o  out  1  DAC channel select.
- dac_wrt_o  out  1  DAC write strobe.
- dac_a_o  out  DAC_DATA_WIDTH  shadow of the last code committed to channel A.
- dac_b_o  out  DAC_DATA_WIDTH  shadow of the last code committed to channel B.
- busy_o  out  1  high whenever the state is not IDLE.
- grant_idx_o  out  $clog2(NUM_REQ)  index of the last granted requester.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state = IDLE; rr pointer = 0.
  - dac_dat_o, dac_a_o and dac_b_o = DAC_MIDSCALE.
  - dac_sel_o, dac_wrt_o, req_ready_o, busy_o and grant_idx_o = 0.
- Handshake:
  - A transfer occurs on a cycle where req_valid_i[i] & req_ready_o[i].
  - req_ready_o is combinational from state and valid. It is asserted only in IDLE, and only for the single requester chosen by the arbiter.
  - A requester must hold valid, data and sel stable until accepted. Deasserting valid before accept withdraws the request; this is legal.
- Arbitration (round-robin):
  - Search starts at pointer p and picks the first i in p, p+1, ... (mod NUM_REQ) with valid set.
  - On accept of i: pointer <= (i+1) mod NUM_REQ and grant_idx_o <= i.
  - If no requester is valid, nothing changes.
- State machine:
  - IDLE: on accept, register the accepted code and sel into the output registers, then go to SETUP.
  - SETUP: dac_dat_o/dac_sel_o are stable and wrt = 0. Next state is STROBE.
  - STROBE: wrt = 1 for exactly one cycle. At the end of this cycle, the shadow register for the selected channel updates. Next state is HOLD with the hold counter loaded to HOLD_CYCLES-1.
  - HOLD: wrt = 0 and data/sel are held. Leave when the counter reaches 0; otherwise decrement.
  - Leaving HOLD returns to IDLE.
- Latency:
  - Accept at cycle T.
  - Bus valid from T+1.
  - dac_wrt_o high during T+2.
  - Shadow visible at T+3.
  - Earliest next accept at T+3+HOLD_CYCLES.
  - Minimum write period is 3+HOLD_CYCLES cycles.
- Outside an active write: dac_dat_o and dac_sel_o keep their last values; they do not return to midscale. dac_wrt_o is never high outside STROBE.
- Simultaneous requests: exactly one grant per IDLE cycle; losers stay pending with ready = 0.
- Fairness: with all requesters valid continuously, grants rotate 0, 1, …, NUM_REQ-1, 0, …
- Reset mid-write:
  - Asynchronous return to the reset values, including dac_wrt_o = 0 immediately.
  - The shadows revert to midscale; no partial shadow update occurs.
- Width: codes pass unmodified; no saturation or offset is applied in this block.

Decomposition:
- Package pdh_dac_pkg holds:
  - state enum dac_wr_state_t {IDLE, SETUP, STROBE, HOLD} (2 bits);
  - DAC_MIDSCALE;
  - channel constants DAC_CH_A = 1'b0 and DAC_CH_B = 1'b1.
- Sub-module rr_arbiter (parameter N) holds the round-robin logic:
  - inputs: req, en, pointer-update strobe;
  - outputs: one-hot grant and the grant index;
  - it owns the rr pointer.
- The FSM, hold counter, output and shadow registers stay in dac_write_arbiter.

Test Plan:
1. Reset then idle: after rst_ni deassert with no requests → dac_dat_o = 0x2000, dac_a_o = dac_b_o = 0x2000, dac_wrt_o = 0, busy_o = 0 for 20 cycles.
2. Single write: req0 valid with data 0x1ABC and sel = 1, accepted at T.
   - Expected: dac_dat_o = 0x1ABC and dac_sel_o = 1 at T+1.
   - dac_wrt_o = 1 only at T+2.
   - dac_b_o = 0x1ABC at T+3; dac_a_o stays 0x2000.
   - req_ready_o[0] = 0 until T+4 (HOLD_CYCLES = 1).
3. Contention: req0 and req1 held valid from the same cycle, carrying 0x0100/A and 0x3F00/B.
   - Expected: req0 is granted first and req1 second.
   - dac_a_o = 0x0100 and dac_b_o = 0x3F00.
   - The two wrt pulses are exactly 4 cycles apart.
4. Fairness: both requesters valid continuously for 8 writes → grant_idx_o sequence 0, 1, 0, 1, 0, 1, 0, 1 and exactly 8 dac_wrt_o pulses.
5. Reset mid-write: assert rst_ni low during STROBE → dac_wrt_o falls within the same cycle. Shadows read 0x2000, and the pending request is re-accepted after release.
6. HOLD_CYCLES = 4: back-to-back requests from req1 → strobe spacing of 7 cycles, and dac_dat_o is stable for 4 cycles after each strobe.
